// File: rtl/udcnt10_checker.sv
// Shadow model and checker for an up/down decade counter sharing the same clock.
// Build option: define UDCNT10_CHK_RESYNC_EN to re-align the model to Q after a mismatch.
module udcnt10_checker (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic       up,
  input  logic [3:0] in,
  input  logic [3:0] q,
  output logic       synced,
  output logic       err,
  output logic       badload,
  output logic       wrap,
  output logic [7:0] err_cnt,
  output logic [3:0] exp
);

  localparam logic [0:0] StUnsync = 1'b0;
  localparam logic [0:0] StSync   = 1'b1;

  localparam logic [3:0] MaxDigit = 4'd9;
  localparam logic [7:0] CntMax   = 8'd255;

  logic [0:0] state_q, state_d;
  logic [3:0] exp_q, exp_d;
  logic       err_q, err_d;
  logic       badload_q, badload_d;
  logic       wrap_q, wrap_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic       load_bad;
  logic       load_good;
  logic       in_sync;
  logic       mismatch;
  logic [3:0] base;
  logic [3:0] counted;
  logic       count_wrap;

  // Gating with load keeps an undriven IN harmless while no load is requested.
  assign load_bad  = load & (in > MaxDigit);
  assign load_good = load & (in <= MaxDigit);
  assign in_sync   = (state_q == StSync);

  // A bad load takes priority over the compare at the same edge.
  assign mismatch = in_sync & ~load_bad & ((q != exp_q) | (q > MaxDigit));

  always_comb begin
    base = exp_q;
`ifdef UDCNT10_CHK_RESYNC_EN
    if (mismatch && (q <= MaxDigit) && !load) begin
      base = q;
    end
`endif
  end

  always_comb begin
    counted    = base;
    count_wrap = 1'b0;
    if (en) begin
      if (up) begin
        if (base == MaxDigit) begin
          counted    = 4'd0;
          count_wrap = 1'b1;
        end else begin
          counted = base + 4'd1;
        end
      end else begin
        if (base == 4'd0) begin
          counted    = MaxDigit;
          count_wrap = 1'b1;
        end else begin
          counted = base - 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    err_d     = 1'b0;
    badload_d = 1'b0;
    wrap_d    = 1'b0;
    err_cnt_d = err_cnt_q;

    if (load_bad) begin
      state_d   = StUnsync;
      exp_d     = 4'd0;
      badload_d = 1'b1;
    end else if (!in_sync) begin
      if (load_good) begin
        state_d = StSync;
        exp_d   = in;
      end
    end else begin
      err_d = mismatch;
      if (mismatch && (err_cnt_q != CntMax)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
      if (load_good) begin
        exp_d = in;
      end else begin
        exp_d  = counted;
        wrap_d = count_wrap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StUnsync;
      exp_q     <= 4'd0;
      err_q     <= 1'b0;
      badload_q <= 1'b0;
      wrap_q    <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      err_q     <= err_d;
      badload_q <= badload_d;
      wrap_q    <= wrap_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign synced  = (state_q == StSync);
  assign err     = err_q;
  assign badload = badload_q;
  assign wrap    = wrap_q;
  assign err_cnt = err_cnt_q;
  assign exp     = exp_q;

endmodule
